// File: rtl/vdp_host_port.sv
`default_nettype none
// ============================================================================
// Module   : vdp_host_port
// Purpose  : CPU-side host interface of the video display processor.
//            TMS9918-style byte-wide CPU protocol with a data port and a
//            control/status port, two-write address/register setup and
//            address auto-increment. Drives the VRAM write port, issues
//            read-ahead fetches over a shared read channel, and holds the
//            VDP control register file.
// Ports    : clk, reset_n            - clock, async active-low reset
//            cpu_wr/cpu_rd/cpu_mode - CPU strobes and port select (1=ctrl)
//            cpu_din/cpu_dout       - CPU write data / registered read data
//            busy                   - read-ahead fetch outstanding
//            vram_we/waddr/wdata    - VRAM write port (one-cycle pulse)
//            vram_rd_req/raddr      - read-ahead request, held until valid
//            vram_rd_valid/rd_data  - read-ahead response
//            status_in/status_clr   - live status byte / clear pulse
//            regs                   - register file, reg n at [8n+7:8n]
// Revision : 1.0 - initial release
// ============================================================================
module vdp_host_port #(
  parameter int ADDR_W   = 12,
  parameter int NUM_REGS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cpu_wr,
  input  logic                    cpu_rd,
  input  logic                    cpu_mode,
  input  logic [7:0]              cpu_din,
  output logic [7:0]              cpu_dout,
  output logic                    busy,
  output logic                    vram_we,
  output logic [ADDR_W-1:0]       vram_waddr,
  output logic [7:0]              vram_wdata,
  output logic                    vram_rd_req,
  output logic [ADDR_W-1:0]       vram_raddr,
  input  logic                    vram_rd_valid,
  input  logic [7:0]              vram_rd_data,
  input  logic [7:0]              status_in,
  output logic                    status_clr,
  output logic [8*NUM_REGS-1:0]   regs
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  state_t                  state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    flag_q;
  logic [7:0]              temp_q;
  logic [7:0]              rb_q;
  logic [7:0]              dout_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       waddr_q;
  logic [7:0]              wdata_q;
  logic                    clr_q;
  logic [8*NUM_REGS-1:0]   regs_q;

  // Strobe decode: a write always wins over a simultaneous read.
  logic                    ctrl_wr_d;
  logic                    data_wr_d;
  logic                    data_rd_d;
  logic                    stat_rd_d;
  logic [ADDR_W-1:0]       addr_inc_d;
  logic [ADDR_W-1:0]       setup_addr_d;

  assign ctrl_wr_d    = cpu_wr &  cpu_mode;
  assign data_wr_d    = cpu_wr & ~cpu_mode;
  assign data_rd_d    = cpu_rd & ~cpu_wr & ~cpu_mode;
  assign stat_rd_d    = cpu_rd & ~cpu_wr &  cpu_mode;
  assign addr_inc_d   = addr_q + c_addr_one;
  // Second control byte is the high byte; bits above ADDR_W are dropped.
  assign setup_addr_d = ADDR_W'({cpu_din, temp_q});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      flag_q  <= 1'b0;
      temp_q  <= '0;
      rb_q    <= '0;
      dout_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      clr_q   <= 1'b0;
      regs_q  <= '0;
    end else begin
      // Pulse outputs default low; they are raised for a single cycle only.
      we_q  <= 1'b0;
      clr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ctrl_wr_d) begin
            if (!flag_q) begin
              temp_q <= cpu_din;
              flag_q <= 1'b1;
            end else begin
              flag_q <= 1'b0;
              if (cpu_din[7]) begin
                for (int n = 0; n < NUM_REGS; n++) begin
                  if (cpu_din[2:0] == 3'(n)) regs_q[8*n +: 8] <= temp_q;
                end
              end else begin
                addr_q <= setup_addr_d;
                // Read setup (bit 6 clear) primes the read-ahead buffer.
                if (!cpu_din[6]) state_q <= S_FETCH;
              end
            end
          end else if (data_wr_d) begin
            we_q    <= 1'b1;
            waddr_q <= addr_q;
            wdata_q <= cpu_din;
            rb_q    <= cpu_din;
            addr_q  <= addr_inc_d;
            flag_q  <= 1'b0;
          end else if (data_rd_d) begin
            dout_q  <= rb_q;
            flag_q  <= 1'b0;
            state_q <= S_FETCH;
          end else if (stat_rd_d) begin
            dout_q  <= status_in;
            clr_q   <= 1'b1;
            flag_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          // CPU strobes are ignored here; the CPU is expected to poll busy.
          if (vram_rd_valid) begin
            rb_q    <= vram_rd_data;
            addr_q  <= addr_inc_d;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_dout    = dout_q;
  assign busy        = (state_q == S_FETCH);
  assign vram_rd_req = (state_q == S_FETCH);
  // Address is frozen during a fetch, so it doubles as the stable read address.
  assign vram_raddr  = addr_q;
  assign vram_we     = we_q;
  assign vram_waddr  = waddr_q;
  assign vram_wdata  = wdata_q;
  assign status_clr  = clr_q;
  assign regs        = regs_q;

endmodule
`default_nettype wire
